// File: rtl/mcu_pkg.sv
// mcu_pkg: shared pipeline types and constants for the MCU core
package mcu_pkg;
  typedef enum logic [1:0] {START, FETCH, HOLD, DRAIN} fetch_state_e;
  localparam logic [31:0] NOP = 32'h0;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: stage register with flush > stall > load priority; idle cycles leave a bubble
module if_id_reg
  import mcu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  always_comb begin
    valid_d = flush ? 1'b0 : stall ? valid_q : load;
    instr_d = flush ? NOP : (stall || !load) ? instr_q : instr_in;
    pc4_d   = (flush || stall || !load) ? pc4_q : pc4_in;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      instr_q <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  assign instr    = instr_q;
  assign pc_plus4 = pc4_q;
  assign valid    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch FSM, skid buffer and IF/ID register
module fetch_stage
  import mcu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] pc_f
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, skid_instr_q, skid_instr_d, skid_pc4_q, skid_pc4_d;
  logic [31:0]  pending_q, pending_d, target, pc_inc, ld_instr, ld_pc4;
  logic         ld, kill;
  assign target = redirect_pc & ~32'h3;
  assign pc_inc = pc_q + PC_INC;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= START;
      pc_q         <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      pending_q    <= pending_d;
    end
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    pending_d    = pending_q;
    case (state_q)
      START: state_d = FETCH;
      FETCH:
        if (redirect && imem_ready) pc_d = target;
        else if (redirect) begin
          pending_d = target;
          state_d   = DRAIN;
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (stall_d) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_inc;
            state_d      = HOLD;
          end
        end
      HOLD:
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_d) state_d = FETCH;
      DRAIN: begin
        if (redirect) pending_d = target;
        if (imem_ready) begin
          pc_d    = redirect ? target : pending_q;
          state_d = FETCH;
        end
      end
      default: state_d = START;
    endcase
  end
  // Fetch-side outputs come from registered state only
  always_comb begin
    imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    imem_addr = pc_q;
    pc_f      = pc_q;
    ld        = !redirect && (((state_q == FETCH) && imem_ready) || (state_q == HOLD));
    kill      = flush_d || (redirect && !stall_d && (state_q != START));
    ld_instr  = (state_q == HOLD) ? skid_instr_q : imem_rdata;
    ld_pc4    = (state_q == HOLD) ? skid_pc4_q : pc_inc;
  end
  if_id_reg u_if_id (
    .clk      (clk),
    .reset    (reset),
    .flush    (kill),
    .stall    (stall_d),
    .load     (ld),
    .instr_in (ld_instr),
    .pc4_in   (ld_pc4),
    .instr    (instr_d),
    .pc_plus4 (pc_plus4_d),
    .valid    (valid_d)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with an IF/ID scoreboard against an addr-as-data memory
module tb_fetch_stage;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b0;
  logic        stall_d = 1'b0, flush_d = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, imem_ready, valid_d;
  logic [31:0] imem_addr, imem_rdata, instr_d, pc_plus4_d, pc_f;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc4_2, pc_f2;
  logic [3:0]  wcnt;
  int          waits = 0;
  int          passed = 0, total = 0;
  exp_t        q[$];
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall_d(stall_d),
    .flush_d(flush_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .pc_f(pc_f)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(1'b1), .imem_rdata(addr2), .stall_d(1'b0),
    .flush_d(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .instr_d(instr2), .pc_plus4_d(pc4_2), .valid_d(valid2), .pc_f(pc_f2)
  );
  always @(posedge clk or negedge reset)
    if (!reset) wcnt <= '0;
    else if (imem_req && imem_ready) wcnt <= '0;
    else if (imem_req) wcnt <= wcnt + 4'd1;
  assign imem_ready = imem_req && (wcnt == waits[3:0]);
  assign imem_rdata = imem_addr;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask
  always @(negedge clk)
    if (reset && valid_d && !stall_d && !flush_d && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("sb_instr", instr_d, e.instr);
      check("sb_pc4", pc_plus4_d, e.pc4);
    end
  task automatic push(input logic [31:0] pc);
    q.push_back({pc, pc + 32'd4});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int w);
    reset = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    redirect = 1'b0;
    waits = w;
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask
  task automatic wait_addr(input logic [31:0] a);
    int n = 0;
    while (imem_addr !== a && n < 50) begin
      step();
      n++;
    end
    check("wait_addr", imem_addr, a);
  endtask
  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check(name, q.size(), 0);
  endtask
  initial begin
    int vcnt;
    logic bad;
    do_reset(0);
    for (int i = 0; i < 6; i++) push(4 * i);
    check("rst_req", imem_req, 0);
    check("rst_pc", pc_f, 0);
    check("rst_valid", valid_d, 0);
    check("rst_instr", instr_d, 0);
    check("rst_pc4", pc_plus4_d, 0);
    check("rst_pc2", pc_f2, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      step();
      check("zw_addr", imem_addr, 4 * i);
      check("zw_req", imem_req, 1);
      if (i == 0) check("wrap_addr0", addr2, 32'hFFFF_FFFC);
      if (i == 1) check("wrap_addr1", addr2, 32'h0);
      if (i == 0) check("zw_valid0", valid_d, 0);
      else begin
        check("zw_valid", valid_d, 1);
        check("zw_instr", instr_d, 4 * (i - 1));
      end
    end
    wait_drain("zw_drain");
    do_reset(2);
    for (int i = 0; i < 5; i++) push(4 * i);
    for (int i = 0; i < 7; i++) begin
      step();
      check("w2_addr", imem_addr, (i / 3) * 4);
    end
    vcnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      vcnt += int'(valid_d);
    end
    check("w2_rate", vcnt, 3);
    wait_drain("w2_drain");
    do_reset(0);
    for (int i = 0; i < 7; i++) push(4 * i);
    wait_addr(32'h10);
    stall_d = 1'b1;
    step();
    check("hold_req", imem_req, 0);
    check("hold_instr", instr_d, 32'hC);
    check("hold_pc", pc_f, 32'h14);
    repeat (2) step();
    stall_d = 1'b0;
    step();
    check("hold_rel_instr", instr_d, 32'h10);
    check("hold_rel_addr", imem_addr, 32'h14);
    wait_drain("hold_drain");
    do_reset(2);
    push(0);
    push(4);
    push(32'h40);
    push(32'h44);
    wait_addr(32'h8);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("drain_addr", imem_addr, 32'h8);
    check("drain_req", imem_req, 1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) check("drain_addr2", imem_addr, 32'h8);
      if (i == 2) check("drain_next", imem_addr, 32'h40);
      bad |= valid_d;
      if (i < 4) step();
    end
    check("drain_bubble", bad, 0);
    wait_drain("drain_sb");
    do_reset(0);
    push(0);
    push(4);
    push(8);
    push(32'h40);
    push(32'h44);
    wait_addr(32'hC);
    redirect = 1'b1;
    redirect_pc = 32'h43;
    step();
    redirect = 1'b0;
    check("rdi_addr", imem_addr, 32'h40);
    check("rdi_valid", valid_d, 0);
    check("rdi_instr", instr_d, 0);
    wait_drain("rdi_sb");
    do_reset(0);
    push(0);
    push(8);
    push(32'hC);
    wait_addr(32'h8);
    stall_d = 1'b1;
    flush_d = 1'b1;
    step();
    check("fs_valid", valid_d, 0);
    check("fs_instr", instr_d, 0);
    check("fs_pc4", pc_plus4_d, 32'h8);
    check("fs_req", imem_req, 0);
    stall_d = 1'b0;
    flush_d = 1'b0;
    step();
    check("fs_skid", instr_d, 32'h8);
    check("fs_addr", imem_addr, 32'hC);
    wait_drain("fs_sb");
    do_reset(2);
    push(0);
    push(4);
    wait_addr(32'h8);
    redirect = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    check("mid_pre_req", imem_req, 1);
    check("mid_pre_pc4", pc_plus4_d, 32'h8);
    #1 reset = 1'b0;
    #1;
    check("mid_req", imem_req, 0);
    check("mid_addr", imem_addr, 0);
    check("mid_pc", pc_f, 0);
    check("mid_valid", valid_d, 0);
    check("mid_instr", instr_d, 0);
    check("mid_pc4", pc_plus4_d, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
